// File: rtl/online_add_ctrl_if.sv
// ----------------------------------------------------------------------------
// online_add_ctrl_if
//   Bundles every non-clock signal of online_add_ctrl: the two requester
//   handshakes with their signed-digit operands, the shared result bus and
//   the bit-serial link to the attached online adder.
//
//   Parameter
//     N            operand length in signed digits (must match the controller)
//
//   Signals (direction seen from the controller, modport slave)
//     req0, req1                            in   operation requests
//     x0_plus/x0_minus/y0_plus/y0_minus     in   requester-0 operands [N-1:0]
//     x1_plus/x1_minus/y1_plus/y1_minus     in   requester-1 operands [N-1:0]
//     gnt0, gnt1                            out  operands captured (1-cycle)
//     done0, done1                          out  result valid (1-cycle)
//     res_plus, res_minus                   out  result digits [N:0]
//     busy                                  out  controller not idle
//     err                                   out  invalid-digit flag
//     adder_clr                             out  adder state clear
//     x_plus/x_minus/y_plus/y_minus         out  digit stream to adder
//     z_plus, z_minus                       in   digit stream from adder
//
//   modport slave  : used by the controller
//   modport master : used by whatever drives requests and models the adder
// ----------------------------------------------------------------------------
interface online_add_ctrl_if #(
  parameter int N = 8
);

  logic         req0;
  logic         req1;
  logic [N-1:0] x0_plus;
  logic [N-1:0] x0_minus;
  logic [N-1:0] y0_plus;
  logic [N-1:0] y0_minus;
  logic [N-1:0] x1_plus;
  logic [N-1:0] x1_minus;
  logic [N-1:0] y1_plus;
  logic [N-1:0] y1_minus;
  logic         gnt0;
  logic         gnt1;
  logic         done0;
  logic         done1;
  logic [N:0]   res_plus;
  logic [N:0]   res_minus;
  logic         busy;
  logic         err;
  logic         adder_clr;
  logic         x_plus;
  logic         x_minus;
  logic         y_plus;
  logic         y_minus;
  logic         z_plus;
  logic         z_minus;

  modport slave (
    input  req0, req1,
    input  x0_plus, x0_minus, y0_plus, y0_minus,
    input  x1_plus, x1_minus, y1_plus, y1_minus,
    output gnt0, gnt1, done0, done1,
    output res_plus, res_minus, busy, err,
    output adder_clr, x_plus, x_minus, y_plus, y_minus,
    input  z_plus, z_minus
  );

  modport master (
    output req0, req1,
    output x0_plus, x0_minus, y0_plus, y0_minus,
    output x1_plus, x1_minus, y1_plus, y1_minus,
    input  gnt0, gnt1, done0, done1,
    input  res_plus, res_minus, busy, err,
    input  adder_clr, x_plus, x_minus, y_plus, y_minus,
    output z_plus, z_minus
  );

endinterface

// File: rtl/online_add_ctrl.sv
// ----------------------------------------------------------------------------
// online_add_ctrl
//   Shares one bit-serial online adder between two requesters. A granted
//   requester's operands are latched, the adder is cleared for one cycle,
//   the operand digits are streamed MSD first for N cycles, DELTA zero
//   digits flush the adder pipeline, and the N+1 result digits shifted in
//   from the adder are presented with a one-cycle done pulse.
//
//   Parameters
//     N      operand length in signed digits (N >= 2)
//     DELTA  online delay of the attached adder (1..4)
//
//   Ports
//     clk    single clock, rising edge
//     rst    synchronous, active-high reset
//     bus    online_add_ctrl_if.slave (requests, operands, grants, done,
//            result, busy, err, adder link)
//
//   Optional build macro
//     ONLINE_ADD_CTRL_DIGIT_CHECK_EN  when defined, an operand digit with
//     plus=minus=1 is fed to the adder as 0 and err is raised in the DONE
//     cycle of that operation; when undefined digits pass unchanged and err
//     is tied low.
//
//   Timing: a grant taken in IDLE at cycle t gives done at t+2+N+DELTA.
//   All outputs are registered and line up with the state they belong to.
// ----------------------------------------------------------------------------
module online_add_ctrl #(
  parameter int N     = 8,
  parameter int DELTA = 2
) (
  input  logic             clk,
  input  logic             rst,
  online_add_ctrl_if.slave bus
);

  // Feed index k runs 0..N+DELTA-1 across FEED and FLUSH.
  localparam int K_W = $clog2(N + DELTA + 1);
  localparam logic [K_W-1:0] K_FEED_LAST  = K_W'(N - 1);
  localparam logic [K_W-1:0] K_FLUSH_LAST = K_W'(N + DELTA - 1);
  localparam logic [K_W-1:0] K_CAP_FIRST  = K_W'(DELTA - 1);
  localparam logic [K_W-1:0] K_ONE        = K_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    FEED  = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [K_W-1:0] k_r;
  logic           ptr_r;        // requester preferred on a tie
  logic           owner_r;      // requester being served

  logic           req_any_s;
  logic           grant_sel_s;
  logic           grant_s;
  logic           load_digit_s;
  logic           capture_s;

  logic [N-1:0]   xp_r;
  logic [N-1:0]   xm_r;
  logic [N-1:0]   yp_r;
  logic [N-1:0]   ym_r;
  logic [1:0]     x_dig_s;
  logic [1:0]     y_dig_s;

  logic           gnt0_r;
  logic           gnt1_r;
  logic           done0_r;
  logic           done1_r;
  logic           busy_r;
  logic           adder_clr_r;
  logic           x_plus_r;
  logic           x_minus_r;
  logic           y_plus_r;
  logic           y_minus_r;
  logic [N:0]     res_plus_r;
  logic [N:0]     res_minus_r;

  // Digit actually sent to the adder for a latched {plus, minus} pair.
  function automatic logic [1:0] fed_digit(input logic p, input logic m);
    logic [1:0] d;
    d = {p, m};
`ifdef ONLINE_ADD_CTRL_DIGIT_CHECK_EN
    if (p && m) begin
      d = 2'b00;
    end else begin
      d = {p, m};
    end
`endif
    return d;
  endfunction

  // Round-robin choice: a lone request wins outright, a tie goes to ptr_r.
  always_comb begin
    req_any_s = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      grant_sel_s = ptr_r;
    end else if (bus.req1) begin
      grant_sel_s = 1'b1;
    end else begin
      grant_sel_s = 1'b0;
    end
    grant_s = (state_r == IDLE) && req_any_s;
  end

  // Next-state logic of the sequencing FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_any_s) begin
          state_nxt_s = CLR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CLR: begin
        state_nxt_s = FEED;
      end
      FEED: begin
        if (k_r == K_FEED_LAST) begin
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = FEED;
        end
      end
      FLUSH: begin
        if (k_r == K_FLUSH_LAST) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = FLUSH;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Per-cycle strobes: which edge loads a new digit and which samples z.
  always_comb begin
    load_digit_s = (state_nxt_s == FEED);
    // z is valid from feed index DELTA-1 onwards; the last capture lands on
    // the edge into DONE, so res is stable for the whole DONE cycle.
    capture_s    = ((state_r == FEED) || (state_r == FLUSH)) && (k_r >= K_CAP_FIRST);
    x_dig_s      = fed_digit(xp_r[N-1], xm_r[N-1]);
    y_dig_s      = fed_digit(yp_r[N-1], ym_r[N-1]);
  end

  // State register, feed index and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      k_r     <= '0;
      ptr_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == FEED) || (state_r == FLUSH)) begin
        k_r <= k_r + K_ONE;
      end else begin
        k_r <= '0;
      end
      if (state_r == DONE) begin
        ptr_r <= ~owner_r;
      end
    end
  end

  // Operand shift registers: loaded at grant, consumed MSD first in FEED.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_r <= 1'b0;
      xp_r    <= '0;
      xm_r    <= '0;
      yp_r    <= '0;
      ym_r    <= '0;
    end else if (grant_s) begin
      owner_r <= grant_sel_s;
      xp_r    <= grant_sel_s ? bus.x1_plus  : bus.x0_plus;
      xm_r    <= grant_sel_s ? bus.x1_minus : bus.x0_minus;
      yp_r    <= grant_sel_s ? bus.y1_plus  : bus.y0_plus;
      ym_r    <= grant_sel_s ? bus.y1_minus : bus.y0_minus;
    end else if (load_digit_s) begin
      xp_r    <= {xp_r[N-2:0], 1'b0};
      xm_r    <= {xm_r[N-2:0], 1'b0};
      yp_r    <= {yp_r[N-2:0], 1'b0};
      ym_r    <= {ym_r[N-2:0], 1'b0};
    end
  end

  // Registered handshake, control and digit-stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0_r      <= 1'b0;
      gnt1_r      <= 1'b0;
      done0_r     <= 1'b0;
      done1_r     <= 1'b0;
      busy_r      <= 1'b0;
      adder_clr_r <= 1'b0;
      x_plus_r    <= 1'b0;
      x_minus_r   <= 1'b0;
      y_plus_r    <= 1'b0;
      y_minus_r   <= 1'b0;
    end else begin
      gnt0_r      <= grant_s && !grant_sel_s;
      gnt1_r      <= grant_s && grant_sel_s;
      done0_r     <= (state_nxt_s == DONE) && !owner_r;
      done1_r     <= (state_nxt_s == DONE) && owner_r;
      busy_r      <= (state_nxt_s != IDLE);
      adder_clr_r <= (state_nxt_s == CLR);
      x_plus_r    <= load_digit_s ? x_dig_s[1] : 1'b0;
      x_minus_r   <= load_digit_s ? x_dig_s[0] : 1'b0;
      y_plus_r    <= load_digit_s ? y_dig_s[1] : 1'b0;
      y_minus_r   <= load_digit_s ? y_dig_s[0] : 1'b0;
    end
  end

  // Result shift register: cleared entering CLR, filled MSD first from z.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_plus_r  <= '0;
      res_minus_r <= '0;
    end else if (state_nxt_s == CLR) begin
      res_plus_r  <= '0;
      res_minus_r <= '0;
    end else if (capture_s) begin
      res_plus_r  <= {res_plus_r[N-1:0], bus.z_plus};
      res_minus_r <= {res_minus_r[N-1:0], bus.z_minus};
    end
  end

`ifdef ONLINE_ADD_CTRL_DIGIT_CHECK_EN
  logic bad_r;
  logic err_r;

  // True when a latched digit is the illegal pair plus=minus=1.
  function automatic logic is_bad_digit(input logic p, input logic m);
    return p & m;
  endfunction

  // Sticky per-operation invalid-digit flag, reported in the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bad_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      if (grant_s) begin
        bad_r <= 1'b0;
      end else if (load_digit_s &&
                   (is_bad_digit(xp_r[N-1], xm_r[N-1]) ||
                    is_bad_digit(yp_r[N-1], ym_r[N-1]))) begin
        bad_r <= 1'b1;
      end
      err_r <= (state_nxt_s == DONE) && bad_r;
    end
  end

  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.gnt0      = gnt0_r;
  assign bus.gnt1      = gnt1_r;
  assign bus.done0     = done0_r;
  assign bus.done1     = done1_r;
  assign bus.busy      = busy_r;
  assign bus.adder_clr = adder_clr_r;
  assign bus.x_plus    = x_plus_r;
  assign bus.x_minus   = x_minus_r;
  assign bus.y_plus    = y_plus_r;
  assign bus.y_minus   = y_minus_r;
  assign bus.res_plus  = res_plus_r;
  assign bus.res_minus = res_minus_r;

endmodule

// File: tb/tb_online_add_ctrl.sv
// ----------------------------------------------------------------------------
// tb_online_add_ctrl
//   Self-checking bench for online_add_ctrl with N=4, DELTA=2. A behavioural
//   radix-2 online adder (delay 2, exact integer residual with rounding
//   selection) answers the controller's digit stream. Expected results come
//   from the operand values with plain integer arithmetic.
// ----------------------------------------------------------------------------
module tb_online_add_ctrl;

  localparam int N     = 4;
  localparam int DELTA = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  online_add_ctrl_if #(.N(N)) bus ();

  online_add_ctrl #(.N(N), .DELTA(DELTA)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compares = 0;
  int fails    = 0;

  // ---------------- behavioural online adder (delay 2) ----------------
  // Values are scaled by 2^(N+4): input digit index k weighs 2^(N+3-k),
  // output digit m weighs 2^(N+4-m).
  int   ad_acc  = 0;
  int   ad_zsum = 0;
  int   ad_k    = 1000;
  int   ad_d, ad_now, ad_m, ad_unit, ad_diff;
  logic ad_zp, ad_zm;

  function automatic int in_wt(input int k);
    if (k < 0 || k > N + 3) return 0;
    return 1 << (N + 3 - k);
  endfunction

  always_comb begin
    ad_d    = int'(bus.x_plus) - int'(bus.x_minus) + int'(bus.y_plus) - int'(bus.y_minus);
    ad_now  = ad_acc + ad_d * in_wt(ad_k);
    ad_m    = ad_k - (DELTA - 1);
    ad_unit = 0;
    ad_diff = 0;
    ad_zp   = 1'b0;
    ad_zm   = 1'b0;
    if (ad_m >= 0 && ad_m <= N) begin
      ad_unit = 1 << (N + 4 - ad_m);
      ad_diff = ad_now - ad_zsum;
      if (2 * ad_diff > ad_unit) ad_zp = 1'b1;
      else if (2 * ad_diff < -ad_unit) ad_zm = 1'b1;
    end
  end

  assign bus.z_plus  = ad_zp;
  assign bus.z_minus = ad_zm;

  always @(posedge clk) begin
    if (rst) begin
      ad_acc <= 0; ad_zsum <= 0; ad_k <= 1000;
    end else if (bus.adder_clr) begin
      ad_acc <= 0; ad_zsum <= 0; ad_k <= 0;
    end else begin
      ad_acc <= ad_now;
      if (ad_m >= 0 && ad_m <= N)
        ad_zsum <= ad_zsum + (ad_zp ? ad_unit : 0) - (ad_zm ? ad_unit : 0);
      if (ad_k < 1000) ad_k <= ad_k + 1;
    end
  end

  // ---------------- helpers ----------------
  logic [N-1:0] op_xp[2], op_xm[2], op_yp[2], op_ym[2];
  logic         pref = 1'b0;   // requester expected to win a tie

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    compares++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int uval(input logic [N-1:0] v);
    return int'(v);
  endfunction

  // Operand sum scaled by 2^N, straight from the digit weights.
  function automatic int exp_sum(input logic w);
    return uval(op_xp[w]) - uval(op_xm[w]) + uval(op_yp[w]) - uval(op_ym[w]);
  endfunction

  function automatic logic exp_bad(input logic w);
`ifdef ONLINE_ADD_CTRL_DIGIT_CHECK_EN
    return |((op_xp[w] & op_xm[w]) | (op_yp[w] & op_ym[w]));
`else
    return 1'b0;
`endif
  endfunction

  // Result value scaled by 2^N (bit N is the integer digit).
  function automatic int res_val();
    int v;
    v = 0;
    for (int i = 0; i <= N; i++)
      v += (int'(bus.res_plus[i]) - int'(bus.res_minus[i])) * (1 << i);
    return v;
  endfunction

  function automatic int all_outs();
    return int'({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.err,
                 bus.adder_clr, bus.x_plus, bus.x_minus, bus.y_plus, bus.y_minus,
                 bus.res_plus, bus.res_minus});
  endfunction

  task automatic drive_ops();
    bus.x0_plus = op_xp[0]; bus.x0_minus = op_xm[0];
    bus.y0_plus = op_yp[0]; bus.y0_minus = op_ym[0];
    bus.x1_plus = op_xp[1]; bus.x1_minus = op_xm[1];
    bus.y1_plus = op_yp[1]; bus.y1_minus = op_ym[1];
  endtask

  task automatic scramble_bus();
    bus.x0_plus = N'($urandom); bus.x0_minus = N'($urandom);
    bus.y0_plus = N'($urandom); bus.y0_minus = N'($urandom);
    bus.x1_plus = N'($urandom); bus.x1_minus = N'($urandom);
    bus.y1_plus = N'($urandom); bus.y1_minus = N'($urandom);
  endtask

  // Request with r0/r1, expect requester w to be served with value ev.
  // keep=1 leaves requests and operands in place (held-request sequences).
  task automatic issue(input logic r0, input logic r1, input logic w,
                       input int ev, input logic eerr, input logic keep,
                       input string tag);
    int lat;
    bus.req0 = r0;
    bus.req1 = r1;
    step();
    chk({tag, "_gnt"},        int'(w ? bus.gnt1 : bus.gnt0), 1);
    chk({tag, "_gnt_other"},  int'(w ? bus.gnt0 : bus.gnt1), 0);
    chk({tag, "_clr"},        int'(bus.adder_clr), 1);
    chk({tag, "_clr_digits"}, int'({bus.x_plus, bus.x_minus, bus.y_plus, bus.y_minus}), 0);
    chk({tag, "_clr_res"},    int'({bus.res_plus, bus.res_minus}), 0);
    chk({tag, "_busy"},       int'(bus.busy), 1);
    if (!keep) begin
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      scramble_bus();
    end
    lat = 1;
    while (!(w ? bus.done1 : bus.done0) && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, "_latency"},     lat, N + DELTA + 2);
    chk({tag, "_res"},         res_val(), ev);
    chk({tag, "_err"},         int'(bus.err), int'(eerr));
    chk({tag, "_done_other"},  int'(w ? bus.done0 : bus.done1), 0);
    chk({tag, "_done_digits"}, int'({bus.adder_clr, bus.x_plus, bus.x_minus, bus.y_plus, bus.y_minus}), 0);
    pref = ~w;
  endtask

  // Cycle after DONE: idle, pulses gone, result held.
  task automatic post_done(input int ev, input string tag);
    step();
    chk({tag, "_idle_busy"}, int'(bus.busy), 0);
    chk({tag, "_idle_done"}, int'({bus.done0, bus.done1, bus.gnt0, bus.gnt1}), 0);
    chk({tag, "_res_hold"},  res_val(), ev);
  endtask

  typedef struct {
    logic         who;
    logic [N-1:0] xp, xm, yp, ym;
    int           exp_val;
    logic         exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int dcount;
    logic bad_exp;

`ifdef ONLINE_ADD_CTRL_DIGIT_CHECK_EN
    bad_exp = 1'b1;
`else
    bad_exp = 1'b0;
`endif
    // who, x+, x-, y+, y-, value*16, err
    vecs[0] = '{1'b0, 4'b1100, 4'b0001, 4'b1000, 4'b0110,  13, 1'b0};
    vecs[1] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000,   0, 1'b0};
    vecs[2] = '{1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b0000,  30, 1'b0};
    vecs[3] = '{1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b1111, -30, 1'b0};
    vecs[4] = '{1'b0, 4'b1010, 4'b0101, 4'b0001, 4'b1000,  -2, 1'b0};
    vecs[5] = '{1'b1, 4'b0000, 4'b1000, 4'b0111, 4'b0000,  -1, 1'b0};
    vecs[6] = '{1'b0, 4'b1100, 4'b0100, 4'b0001, 4'b0000,   9, bad_exp};

    rst = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    for (int q = 0; q < 2; q++) begin
      op_xp[q] = '0; op_xm[q] = '0; op_yp[q] = '0; op_ym[q] = '0;
    end
    drive_ops();
    step(); step(); step();
    rst = 1'b0;
    chk("reset_outputs", all_outs(), 0);
    step();
    chk("reset_idle", all_outs(), 0);

    // Table-driven single operations (lone requests, operands scrambled after grant).
    for (int i = 0; i < 7; i++) begin
      op_xp[vecs[i].who] = vecs[i].xp; op_xm[vecs[i].who] = vecs[i].xm;
      op_yp[vecs[i].who] = vecs[i].yp; op_ym[vecs[i].who] = vecs[i].ym;
      drive_ops();
      issue(~vecs[i].who, vecs[i].who, vecs[i].who, vecs[i].exp_val, vecs[i].exp_err,
            1'b0, $sformatf("vec%0d", i));
      post_done(vecs[i].exp_val, $sformatf("vec%0d", i));
    end

    // Both requests from reset, held: requester 0 first, then strict alternation.
    rst = 1'b1;
    step();
    rst = 1'b0;
    pref = 1'b0;
    op_xp[0] = 4'b1100; op_xm[0] = 4'b0001; op_yp[0] = 4'b1000; op_ym[0] = 4'b0110;
    op_xp[1] = 4'b1111; op_xm[1] = 4'b0000; op_yp[1] = 4'b1111; op_ym[1] = 4'b0000;
    drive_ops();
    issue(1'b1, 1'b1, 1'b0, 13, 1'b0, 1'b1, "tie_a");
    post_done(13, "tie_a");
    issue(1'b1, 1'b1, 1'b1, 30, 1'b0, 1'b1, "tie_b");
    post_done(30, "tie_b");
    issue(1'b1, 1'b1, 1'b0, 13, 1'b0, 1'b1, "tie_c");
    post_done(13, "tie_c");
    issue(1'b1, 1'b1, 1'b1, 30, 1'b0, 1'b0, "tie_d");
    post_done(30, "tie_d");

    // Serve requester 0 so a tie would now favour requester 1.
    drive_ops();
    issue(1'b1, 1'b0, 1'b0, 13, 1'b0, 1'b1, "pre_abort");
    bus.req0 = 1'b0;
    post_done(13, "pre_abort");

    // Abort with reset in the second FEED cycle.
    bus.req0 = 1'b1;
    step();
    chk("abort_gnt", int'(bus.gnt0), 1);
    bus.req0 = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_outputs", all_outs(), 0);
    pref = 1'b0;
    dcount = 0;
    for (int c = 0; c < N + DELTA + 4; c++) begin
      step();
      if (bus.done0 || bus.done1) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    issue(1'b1, 1'b1, 1'b0, 13, 1'b0, 1'b0, "abort_ptr");
    post_done(13, "abort_ptr");

    // Random requests and operands against the value/arbitration model.
    for (int it = 0; it < 16; it++) begin
      int   sel;
      logic r0, r1, w;
      sel = $urandom_range(1, 3);
      r0  = sel[0];
      r1  = sel[1];
      for (int q = 0; q < 2; q++) begin
        op_xp[q] = N'($urandom); op_xm[q] = N'($urandom);
        op_yp[q] = N'($urandom); op_ym[q] = N'($urandom);
      end
      drive_ops();
      w = (r0 && r1) ? pref : r1;
      issue(r0, r1, w, exp_sum(w), exp_bad(w), 1'b0, $sformatf("rnd%0d", it));
      post_done(exp_sum(w), $sformatf("rnd%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule

// File: doc/online_add_ctrl.md
ONLINE_ADD_CTRL -- requirements
Module: online_add_ctrl

Interface
REQ-001 SHALL have parameter N, default 8: operand length in signed digits, MSD first, N>=2.
REQ-002 SHALL have parameter DELTA, default 2: online delay of the attached online adder, 1<=DELTA<=4.
REQ-003 SHALL have clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have req0, req1  in  1 each  operation request from requester 0 / 1.
REQ-006 SHALL have x0_plus, x0_minus, y0_plus, y0_minus  in  N each  requester-0 operands; digit i = plus[i]-minus[i]; bit N-1 = MSD.
REQ-007 SHALL have x1_plus, x1_minus, y1_plus, y1_minus  in  N each  requester-1 operands, same encoding.
REQ-008 SHALL have gnt0, gnt1  out  1 each  one-cycle pulse: operands of that requester captured.
REQ-009 SHALL have done0, done1  out  1 each  one-cycle pulse: result for that requester valid.
REQ-010 SHALL have res_plus, res_minus  out  N+1 each  result digits, bit N = most significant (integer) digit.
REQ-011 SHALL have busy  out  1  high in every state except IDLE.
REQ-012 SHALL have err  out  1  invalid-digit flag, valid with done0/done1.
REQ-013 SHALL have adder_clr  out  1  clears the online adder's internal state.
REQ-014 SHALL have x_plus, x_minus, y_plus, y_minus  out  1 each  digit stream into the adder.
REQ-015 SHALL have z_plus, z_minus  in  1 each  digit stream from the adder.

Function
REQ-016 SHALL implement states IDLE, CLR, FEED, FLUSH, DONE.
REQ-017 IDLE: if any req high, SHALL grant, latch that requester's four operand vectors, pulse its gnt, go to CLR; otherwise stay.
REQ-018 SHALL arbitrate round-robin: if req0 and req1 both high, grant the requester not served last; a lone request is granted immediately.
REQ-019 CLR: SHALL hold adder_clr=1 for exactly one cycle with all digit outputs 0, then go to FEED.
REQ-020 FEED: SHALL drive one operand digit pair per cycle for N cycles, MSD first, then go to FLUSH.
REQ-021 FLUSH: SHALL drive zero digits (all four outputs 0) for DELTA cycles, then go to DONE.
REQ-022 SHALL number feed cycles k=0..N+DELTA-1 across FEED+FLUSH and shift z_plus/z_minus into res MSD-first at k=DELTA-1..N+DELTA-1 (N+1 captures).
REQ-023 DONE: SHALL pulse done of the served requester for one cycle with res stable, update round-robin pointer, return to IDLE.
REQ-024 res SHALL hold its value from DONE until the next CLR, which clears it to 0.
REQ-025 Latency: grant in IDLE at cycle t SHALL yield done at cycle t+2+N+DELTA.
REQ-026 Requests arriving outside IDLE SHALL be ignored until IDLE is reached; a req held through DONE is granted the cycle after DONE.
REQ-027 Operand inputs SHALL be sampled only in the grant cycle; later changes SHALL not affect the operation.
REQ-028 adder_clr, x/y digit outputs SHALL be 0 in IDLE and DONE.

Reset
REQ-029 rst high at a clock edge SHALL force IDLE, round-robin pointer to requester 0, all outputs and res to 0, from any state including mid-FEED/FLUSH.
REQ-030 An operation aborted by reset SHALL produce no done pulse.

Configuration
REQ-031 With ONLINE_ADD_CTRL_DIGIT_CHECK_EN defined, a latched digit with plus=minus=1 SHALL be fed as 0 and err SHALL be 1 in the DONE cycle.
REQ-032 Without ONLINE_ADD_CTRL_DIGIT_CHECK_EN, digits SHALL pass unchanged and err SHALL be tied 0.

Verification (N=4, DELTA=2, adder with delay 2)
REQ-033 req0 with x=(1,1,0,-1), y=(1,-1,-1,0) -> gnt0 next edge, done0 8 cycles after grant, res value = 13/16.
REQ-034 req0 and req1 high together from reset -> requester 0 served first, requester 1 granted the cycle after done0.
REQ-035 req1 held continuously, req0 re-raised after done0 -> strict alternation of grants 1,0,1,...
REQ-036 rst asserted at second FEED cycle -> next cycle IDLE, all outputs 0, no done pulse, pointer back to 0.
REQ-037 Operand changed after gnt0 -> res unchanged vs unmodified run; x=y=0 -> res value 0.
REQ-038 With macro, x digit 2 = (plus=1,minus=1) -> err=1 at done, result as if digit 0; without macro err stays 0.
